// File: rtl/riscv_pkg.sv
// Shared core constants: datapath width, register addressing and shifter shamt width.
package riscv_pkg;
    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int REG_N   = 1 << REG_AW;
    localparam int SHAMT_W = 5;
    localparam logic [REG_AW-1:0] REG_X0 = 5'd0;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: x0 masking, reset masking and optional
// same-cycle write bypass. Zero latency; no backpressure.
module regfile_read_port #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic            en_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] regs_i [NREG],
    input  logic            we_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] data_o
);
    logic hit;

    generate
        if (BYPASS) begin : g_byp
            // addr_i != 0 is checked below, so a hit already implies a non-x0 write
            assign hit = we_i && (wr_addr_i == addr_i);
        end else begin : g_nobyp
            logic unused_wr;
            assign unused_wr = ^{we_i, wr_addr_i, wr_data_i};
            assign hit       = 1'b0;
        end
    endgenerate

    always_comb begin
        data_o = '0;
        if (en_i && (addr_i != '0)) begin
            data_o = hit ? wr_data_i : regs_i[addr_i];
        end
    end
endmodule

// File: rtl/riscv_regfile.sv
// Integer register file: two combinational read ports, one synchronous write port,
// optional write-to-read bypass, an unbypassed debug port and a saturating write counter.
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int NREG   = riscv_pkg::REG_N,
    parameter int AW     = riscv_pkg::REG_AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [15:0]     wr_count
);
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] rd_view [NREG];
    logic [15:0]     wr_count_q, wr_count_d;
    logic            wr_commit;

    assign wr_commit = we && (rd_addr != AW'(REG_X0));

    // x0 has no storage; entry 0 of the read view is a hard zero
    always_comb begin
        rd_view[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            rd_view[i] = regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[rd_addr] <= rd_data;
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

    regfile_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS)) u_rs1 (
        .en_i(rst_n), .addr_i(rs1_addr), .regs_i(rd_view),
        .we_i(we), .wr_addr_i(rd_addr), .wr_data_i(rd_data), .data_o(rs1_data)
    );

    regfile_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS)) u_rs2 (
        .en_i(rst_n), .addr_i(rs2_addr), .regs_i(rd_view),
        .we_i(we), .wr_addr_i(rd_addr), .wr_data_i(rd_data), .data_o(rs2_data)
    );

    regfile_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1'b0)) u_dbg (
        .en_i(rst_n), .addr_i(dbg_addr), .regs_i(rd_view),
        .we_i(we), .wr_addr_i(rd_addr), .wr_data_i(rd_data), .data_o(dbg_data)
    );
endmodule

// File: tb/tb_riscv_regfile.sv
// Bench for riscv_regfile: one bypassing and one non-bypassing instance share stimulus;
// a reference register model feeds expected values into a scoreboard queue.
module tb_riscv_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
    logic        we;
    logic [31:0] rd_data;

    logic [31:0] b_rs1, b_rs2, b_dbg;
    logic [15:0] b_cnt;
    logic [31:0] n_rs1, n_rs2, n_dbg;
    logic [15:0] n_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_regs [32];
    logic [15:0] model_cnt;
    logic [31:0] sb_q [$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    riscv_regfile #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs1_data(b_rs1),
        .rs2_addr(rs2_addr), .rs2_data(b_rs2),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .dbg_addr(dbg_addr), .dbg_data(b_dbg), .wr_count(b_cnt)
    );

    riscv_regfile #(.BYPASS(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs1_data(n_rs1),
        .rs2_addr(rs2_addr), .rs2_data(n_rs2),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .dbg_addr(dbg_addr), .dbg_data(n_dbg), .wr_count(n_cnt)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_cnt = 16'h0;
    endtask

    // One clock edge with the currently driven write inputs; model follows the edge.
    task automatic clock_write();
        @(posedge clk);
        if (rst_n && we && rd_addr != 5'd0) begin
            model_regs[rd_addr] = rd_data;
            if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        end
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; rd_addr = a; rd_data = d;
        clock_write();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b0; rd_addr = 5'd0; rd_data = 32'h0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
        model_reset();
        #12;
        sb_q.push_back({16'h0, model_cnt});
        exp_v = sb_q.pop_front(); checks++;
        if ({16'h0, b_cnt} !== exp_v) begin errors++; $display("FAIL reset_count got=%h want=%h", b_cnt, exp_v); end
        @(negedge clk); rst_n = 1'b1;
        do_write(5'd5, 32'hDEAD_BEEF);
        dbg_addr = 5'd5; #1;
        sb_q.push_back(model_regs[5]);
        exp_v = sb_q.pop_front(); checks++;
        if (b_dbg !== exp_v) begin errors++; $display("FAIL pre_reset_x5 got=%h want=%h", b_dbg, exp_v); end
        // Mid-cycle asynchronous reset, no clock edge before sampling
        @(negedge clk); #2;
        rst_n = 1'b0; model_reset(); #1;
        sb_q.push_back(model_regs[5]);
        sb_q.push_back({16'h0, model_cnt});
        exp_v = sb_q.pop_front(); checks++;
        if (b_dbg !== exp_v) begin errors++; $display("FAIL async_reset_x5 got=%h want=%h", b_dbg, exp_v); end
        exp_v = sb_q.pop_front(); checks++;
        if ({16'h0, b_cnt} !== exp_v) begin errors++; $display("FAIL async_reset_count got=%h want=%h", b_cnt, exp_v); end
        // Writes and bypass are suppressed while reset is held
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'h5555_AAAA; rs1_addr = 5'd5; #1;
        checks++;
        if (b_rs1 !== 32'h0) begin errors++; $display("FAIL reset_bypass_masked got=%h want=0", b_rs1); end
        clock_write();
        we = 1'b0; #1;
        checks++;
        if (b_dbg !== 32'h0) begin errors++; $display("FAIL reset_write_ignored got=%h want=0", b_dbg); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_x0_write();
        logic [15:0] cnt_before;
        cnt_before = model_cnt;
        do_write(5'd0, 32'hFFFF_FFFF);
        rs1_addr = 5'd0; #1;
        sb_q.push_back(model_regs[0]);
        exp_v = sb_q.pop_front(); checks++;
        if (b_rs1 !== exp_v) begin errors++; $display("FAIL x0_read got=%h want=%h", b_rs1, exp_v); end
        checks++;
        if (b_cnt !== cnt_before) begin errors++; $display("FAIL x0_count got=%h want=%h", b_cnt, cnt_before); end
        // x0 is never bypassed even with a live write to it
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hCAFE_F00D; rs2_addr = 5'd0; #1;
        checks++;
        if (b_rs2 !== 32'h0) begin errors++; $display("FAIL x0_no_bypass got=%h want=0", b_rs2); end
        we = 1'b0;
    endtask

    task automatic test_basic();
        do_write(5'd7, 32'h0000_0003);
        do_write(5'd8, 32'h0000_00F1);
        rs1_addr = 5'd7; rs2_addr = 5'd8; #1;
        sb_q.push_back(model_regs[7]);
        sb_q.push_back(model_regs[8]);
        exp_v = sb_q.pop_front(); checks++;
        if (b_rs1 !== exp_v) begin errors++; $display("FAIL basic_rs1 got=%h want=%h", b_rs1, exp_v); end
        exp_v = sb_q.pop_front(); checks++;
        if (b_rs2 !== exp_v) begin errors++; $display("FAIL basic_rs2 got=%h want=%h", b_rs2, exp_v); end
        checks++;
        if (b_rs2[4:0] !== 5'd17) begin errors++; $display("FAIL basic_shamt got=%0d want=17", b_rs2[4:0]); end
        sb_q.push_back({16'h0, model_cnt});
        exp_v = sb_q.pop_front(); checks++;
        if ({16'h0, b_cnt} !== exp_v) begin errors++; $display("FAIL basic_count got=%h want=%h", b_cnt, exp_v); end
    endtask

    task automatic test_bypass();
        we = 1'b1; rd_addr = 5'd9; rd_data = 32'h1234_5678;
        rs1_addr = 5'd9; rs2_addr = 5'd9; dbg_addr = 5'd9; #1;
        sb_q.push_back(rd_data);
        sb_q.push_back(rd_data);
        sb_q.push_back(model_regs[9]);
        sb_q.push_back(model_regs[9]);
        sb_q.push_back(model_regs[9]);
        exp_v = sb_q.pop_front(); checks++;
        if (b_rs1 !== exp_v) begin errors++; $display("FAIL byp_rs1 got=%h want=%h", b_rs1, exp_v); end
        exp_v = sb_q.pop_front(); checks++;
        if (b_rs2 !== exp_v) begin errors++; $display("FAIL byp_rs2 got=%h want=%h", b_rs2, exp_v); end
        exp_v = sb_q.pop_front(); checks++;
        if (b_dbg !== exp_v) begin errors++; $display("FAIL byp_dbg_old got=%h want=%h", b_dbg, exp_v); end
        exp_v = sb_q.pop_front(); checks++;
        if (n_rs1 !== exp_v) begin errors++; $display("FAIL nobyp_rs1_old got=%h want=%h", n_rs1, exp_v); end
        exp_v = sb_q.pop_front(); checks++;
        if (n_rs2 !== exp_v) begin errors++; $display("FAIL nobyp_rs2_old got=%h want=%h", n_rs2, exp_v); end
        clock_write();
        we = 1'b0; #1;
        sb_q.push_back(model_regs[9]);
        exp_v = sb_q.pop_front(); checks++;
        if (n_rs1 !== exp_v) begin errors++; $display("FAIL nobyp_rs1_new got=%h want=%h", n_rs1, exp_v); end
    endtask

    task automatic test_back_to_back();
        we = 1'b1; rd_addr = 5'd10; rd_data = 32'hAAAA_0001;
        clock_write();
        rd_data = 32'hBBBB_0002; rs1_addr = 5'd10; dbg_addr = 5'd10; #1;
        sb_q.push_back(rd_data);
        sb_q.push_back(model_regs[10]);
        exp_v = sb_q.pop_front(); checks++;
        if (b_rs1 !== exp_v) begin errors++; $display("FAIL b2b_bypass got=%h want=%h", b_rs1, exp_v); end
        exp_v = sb_q.pop_front(); checks++;
        if (n_rs1 !== exp_v) begin errors++; $display("FAIL b2b_nobyp got=%h want=%h", n_rs1, exp_v); end
        clock_write();
        we = 1'b0; #1;
        sb_q.push_back(model_regs[10]);
        exp_v = sb_q.pop_front(); checks++;
        if (b_dbg !== exp_v) begin errors++; $display("FAIL b2b_last_wins got=%h want=%h", b_dbg, exp_v); end
    endtask

    task automatic test_saturation();
        we = 1'b1; rd_addr = 5'd1;
        for (int i = 0; i < 65540; i++) begin
            rd_data = 32'h5A00_0000 ^ i;
            clock_write();
        end
        we = 1'b0; rs1_addr = 5'd1; #1;
        sb_q.push_back({16'h0, model_cnt});
        sb_q.push_back({16'h0, model_cnt});
        sb_q.push_back(model_regs[1]);
        exp_v = sb_q.pop_front(); checks++;
        if ({16'h0, b_cnt} !== exp_v) begin errors++; $display("FAIL sat_count_byp got=%h want=%h", b_cnt, exp_v); end
        exp_v = sb_q.pop_front(); checks++;
        if ({16'h0, n_cnt} !== exp_v) begin errors++; $display("FAIL sat_count_nobyp got=%h want=%h", n_cnt, exp_v); end
        exp_v = sb_q.pop_front(); checks++;
        if (b_rs1 !== exp_v) begin errors++; $display("FAIL sat_last_value got=%h want=%h", b_rs1, exp_v); end
        // Writes keep committing once saturated
        do_write(5'd2, 32'h0BAD_F00D);
        dbg_addr = 5'd2; #1;
        sb_q.push_back(model_regs[2]);
        exp_v = sb_q.pop_front(); checks++;
        if (b_dbg !== exp_v || b_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_commit got=%h/%h want=%h/ffff", b_dbg, b_cnt, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_x0_write();
        test_basic();
        test_bypass();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
